// File: rtl/dds_pkg.sv
// dds_pkg: register map, CTRL field positions, waveform select and the
// quarter-wave sine table shared by the DDS phaser core and its wave generator.
package dds_pkg;

    localparam logic [15:0] ADDR_OFFSET = 16'h0010;
    localparam logic [15:0] ADDR_FTW    = 16'h0020;
    localparam logic [15:0] ADDR_CTRL   = 16'h0030;

    localparam int unsigned CTRL_W        = 4;
    localparam int unsigned CTRL_RUN_BIT  = 0;
    localparam int unsigned CTRL_OEN_BIT  = 1;
    localparam int unsigned CTRL_WAVE_LSB = 2;

    typedef enum logic [1:0] {
        SINE = 2'b00,
        TRI  = 2'b01,
        SAW  = 2'b10,
        SQR  = 2'b11
    } wave_e;

    // round(32767 * sin(pi/2 * i/64)), i = 0..64
    localparam logic [15:0] SINE_QTR [65] = '{
        16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
        16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
        16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
        16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
        16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
        16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
        16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
        16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
        16'd32767
    };

endpackage

// File: rtl/GSR.sv
// GSR: behavioural stand-in for the Gowin global set/reset primitive so the
// core can be simulated and linted outside the vendor flow. It has no function.
module GSR (
    input logic GSRI
);
    logic unused_gsri;
    assign unused_gsri = GSRI;
endmodule

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: combinational phase-to-amplitude stage (sine/triangle/sawtooth/square).
// Works on the top 16 bits of the phase; sine uses the quarter-wave table with symmetry.
module dds_wave_gen #(
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LUT_AW  = 8
) (
    input  dds_pkg::wave_e            wave,
    input  logic [PHASE_W-1:0]        p,
    output logic signed [DATA_W-1:0]  sample
);
    import dds_pkg::*;

    localparam logic [LUT_AW-2:0] QTR_LEN = (LUT_AW-1)'(2 ** (LUT_AW-2));

    logic [15:0]        p16;
    logic [LUT_AW-1:0]  idx;
    logic [LUT_AW-3:0]  k;
    logic [LUT_AW-2:0]  tidx;
    logic [15:0]        mag;
    logic [15:0]        dbl;
    logic signed [15:0] s16;

    assign p16 = p[PHASE_W-1 -: 16];
    assign idx = p16[15 -: LUT_AW];
    assign k   = idx[LUT_AW-3:0];

    // Select waveform; sine mirrors the index in odd quadrants and negates in the lower half
    always_comb begin
        tidx = {1'b0, k};
        mag  = '0;
        dbl  = {p16[14:0], 1'b0};
        s16  = '0;
        if (idx[LUT_AW-2]) begin
            tidx = QTR_LEN - {1'b0, k};
        end
        mag = SINE_QTR[tidx];
        case (wave)
            SINE: s16 = idx[LUT_AW-1] ? (~mag + 16'd1) : mag;
            TRI:  s16 = p16[15] ? (16'h7FFF - dbl) : (dbl ^ 16'h8000);
            SAW:  s16 = p16 ^ 16'h8000;
            SQR:  s16 = p16[15] ? 16'h8001 : 16'h7FFF;
            default: s16 = '0;
        endcase
    end

    assign sample = DATA_W'(s16);

endmodule

// File: rtl/dds_phaser_core.sv
// dds_phaser_core: register-programmed DDS with a 16-bit phase accumulator and a
// two-stage output pipeline (phase+offset, then waveform lookup into dout).
// Build option DDS_PHASE_OFFSET_EN: adds the writable OFFSET register at 0x0010.
module dds_phaser_core #(
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned LUT_AW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] dout
);
    import dds_pkg::*;

    logic [PHASE_W-1:0] ftw_q,      ftw_d;
    logic [CTRL_W-1:0]  ctrl_q,     ctrl_d;
    logic [PHASE_W-1:0] phase_q,    phase_d;
    logic [PHASE_W-1:0] p_q,        p_d;
    wave_e              wave_s1_q,  wave_s1_d;
    logic               oen_s1_q,   oen_s1_d;
    logic [DATA_W-1:0]  dout_q,     dout_d;
    logic               valid_q,    valid_d;
`ifdef DDS_PHASE_OFFSET_EN
    logic [PHASE_W-1:0] offset_q,   offset_d;
`endif

    logic signed [DATA_W-1:0] sample;

    GSR u_gsr (
        .GSRI (1'b1)
    );

    dds_wave_gen #(
        .PHASE_W (PHASE_W),
        .DATA_W  (DATA_W),
        .LUT_AW  (LUT_AW)
    ) u_wave_gen (
        .wave   (wave_s1_q),
        .p      (p_q),
        .sample (sample)
    );

    // Register writes, accumulator advance and next pipeline contents
    always_comb begin
        ftw_d  = ftw_q;
        ctrl_d = ctrl_q;
`ifdef DDS_PHASE_OFFSET_EN
        offset_d = offset_q;
`endif
        if (wr) begin
            if (waddr == ADDR_W'(ADDR_FTW)) begin
                ftw_d = PHASE_W'(wdata);
            end
            if (waddr == ADDR_W'(ADDR_CTRL)) begin
                ctrl_d = wdata[CTRL_W-1:0];
            end
`ifdef DDS_PHASE_OFFSET_EN
            if (waddr == ADDR_W'(ADDR_OFFSET)) begin
                offset_d = PHASE_W'(wdata);
            end
`endif
        end

        phase_d = ctrl_q[CTRL_RUN_BIT] ? (phase_q + ftw_q) : phase_q;

`ifdef DDS_PHASE_OFFSET_EN
        p_d = phase_q + offset_q;
`else
        p_d = phase_q;
`endif
        wave_s1_d = wave_e'(ctrl_q[CTRL_WAVE_LSB +: 2]);
        oen_s1_d  = ctrl_q[CTRL_OEN_BIT];

        dout_d  = oen_s1_q ? DATA_W'(sample) : '0;
        valid_d = oen_s1_q;
    end

    // State update; reset wins over a write in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ftw_q     <= '0;
            ctrl_q    <= '0;
            phase_q   <= '0;
            p_q       <= '0;
            wave_s1_q <= SINE;
            oen_s1_q  <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
`ifdef DDS_PHASE_OFFSET_EN
            offset_q  <= '0;
`endif
        end else begin
            ftw_q     <= ftw_d;
            ctrl_q    <= ctrl_d;
            phase_q   <= phase_d;
            p_q       <= p_d;
            wave_s1_q <= wave_s1_d;
            oen_s1_q  <= oen_s1_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
`ifdef DDS_PHASE_OFFSET_EN
            offset_q  <= offset_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_dds_phaser_core.sv
// tb_dds_phaser_core: directed self-checking bench for dds_phaser_core.
module tb_dds_phaser_core;

    localparam logic [15:0] A_OFS  = 16'h0010;
    localparam logic [15:0] A_FTW  = 16'h0020;
    localparam logic [15:0] A_CTRL = 16'h0030;
    localparam logic [15:0] A_BAD  = 16'h0040;

`ifdef DDS_PHASE_OFFSET_EN
    localparam bit OFS_EN = 1'b1;
`else
    localparam bit OFS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        out_valid;
    logic [15:0] dout;

    int checks = 0;
    int errors = 0;

    dds_phaser_core #(
        .PHASE_W (16),
        .DATA_W  (16),
        .ADDR_W  (16),
        .LUT_AW  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .waddr     (waddr),
        .wdata     (wdata),
        .out_valid (out_valid),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present one bus cycle, let the edge capture it, settle, then drop the strobe
    task automatic step(input logic w, input logic [15:0] a, input logic [15:0] d);
        wr    = w;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sh;
        rst   = 1'b1;
        wr    = 1'b0;
        waddr = '0;
        wdata = '0;

        // Reset held 10 cycles
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, '0);
            check("rst_dout",  $signed(dout), 0);
            check("rst_valid", out_valid, 0);
            check("rst_phase", dut.phase_q, 0);
        end
        rst = 1'b0;

        // Square: CTRL=0xF then FTW=2
        step(1'b1, A_CTRL, 16'h000F);
        step(1'b1, A_FTW,  16'h0002);
        check("sq_valid_lat", out_valid, 0);
        step(1'b0, '0, '0);
        check("sq_valid_rise", out_valid, 1);
        check("sq_first", $signed(dout), 32767);
        for (int k = 1; k <= 16385; k++) begin
            step(1'b0, '0, '0);
            if (k == 1)     check("sq_pos_early", $signed(dout), 32767);
            if (k == 16384) check("sq_pos_last",  $signed(dout), 32767);
            if (k == 16385) check("sq_neg_first", $signed(dout), -32767);
        end

        // Mid-waveform reset coinciding with a CTRL write
        rst = 1'b1;
        step(1'b1, A_CTRL, 16'h000F);
        check("midrst_dout",  $signed(dout), 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_phase", dut.phase_q, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0);
        check("rstprio_valid", out_valid, 0);
        check("rstprio_dout",  $signed(dout), 0);

        // Sine, FTW=0x100; later RUN off (freeze) then OEN off
        step(1'b1, A_FTW,  16'h0100);
        step(1'b1, A_CTRL, 16'h0003);
        step(1'b0, '0, '0);
        check("sin_valid_lat", out_valid, 0);
        for (int s = 0; s <= 209; s++) begin
            if (s == 201)      step(1'b1, A_CTRL, 16'h0002);
            else if (s == 207) step(1'b1, A_CTRL, 16'h0001);
            else               step(1'b0, '0, '0);
            case (s)
                0:   begin check("sin_s0", $signed(dout), 0); check("sin_v0", out_valid, 1); end
                1:   check("sin_s1",   $signed(dout), 804);
                2:   check("sin_s2",   $signed(dout), 1608);
                32:  check("sin_s32",  $signed(dout), 23170);
                64:  check("sin_s64",  $signed(dout), 32767);
                96:  check("sin_s96",  $signed(dout), 23170);
                128: check("sin_s128", $signed(dout), 0);
                160: check("sin_s160", $signed(dout), -23170);
                192: check("sin_s192", $signed(dout), -32767);
                200: check("sin_s200", $signed(dout), -32137);
                202: check("frz_s202", $signed(dout), -31785);
                203: check("frz_s203", $signed(dout), -31580);
                206: begin check("frz_hold", $signed(dout), -31580); check("frz_valid", out_valid, 1); end
                208: begin check("oen_lag_dout", $signed(dout), -31580); check("oen_lag_valid", out_valid, 1); end
                209: begin check("oen_off_dout", $signed(dout), 0); check("oen_off_valid", out_valid, 0); end
                default: ;
            endcase
        end

        // Sawtooth FTW=0x1000, with an unmapped write and an OFFSET write mid-run
        rst = 1'b1;
        step(1'b0, '0, '0);
        rst = 1'b0;
        step(1'b1, A_FTW,  16'h1000);
        step(1'b1, A_CTRL, 16'h000B);
        step(1'b0, '0, '0);
        check("saw_valid_lat", out_valid, 0);
        for (int s = 0; s <= 17; s++) begin
            if (s == 0)      step(1'b1, A_BAD, 16'h0000);
            else if (s == 1) step(1'b1, A_OFS, 16'h4000);
            else             step(1'b0, '0, '0);
            sh = s + ((OFS_EN && s >= 3) ? 4 : 0);
            check("saw", $signed(dout), -32768 + 4096 * (sh % 16));
            if (s == 0 || s == 17) check("saw_valid", out_valid, 1);
        end

        // Phase offset on sine at phase 0
        rst = 1'b1;
        step(1'b0, '0, '0);
        rst = 1'b0;
        step(1'b1, A_OFS,  16'h4000);
        step(1'b1, A_CTRL, 16'h0002);
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        check("ofs_sine",  $signed(dout), OFS_EN ? 32767 : 0);
        check("ofs_valid", out_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_phaser_core.md
Name: dds_phaser_core

Overview:
Register-programmed direct digital synthesizer that generates a periodic signed 16-bit waveform (sine, triangle, sawtooth or square) from a 16-bit phase accumulator. The block sits behind a simple write-only register bus (wr/waddr/wdata) driven by the control plane and feeds the phaser datapath through dout/out_valid. The Gowin global set/reset primitive (GSR) is instantiated at top level, held inactive, and has no function in this block.

Parameters:
PHASE_W, 16, phase accumulator and tuning word width
DATA_W, 16, output sample width (two's complement)
ADDR_W, 16, register address width
LUT_AW, 8, phase bits used for the sine lookup (256 points per period)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr  input  1  register write strobe, one write per cycle it is high
waddr  input  ADDR_W  register address
wdata  input  16  register write data
out_valid  output  1  dout carries a valid sample this cycle
dout  output  DATA_W  signed waveform sample

Behaviour:
- Reset (rst=1 at clk edge): FTW=0, CTRL=0, OFFSET=0, phase=0, all pipeline registers=0, dout=0, out_valid=0. A reset mid-operation takes priority over a simultaneous write.
- Register map (write-only; other addresses are ignored):
  - 0x0020 FTW, 16 bits.
  - 0x0030 CTRL[3:0]: bit0 = RUN (accumulator advance), bit1 = OEN (output enable), bits[3:2] = WAVE (00 sine, 01 triangle, 10 sawtooth, 11 square). Upper bits of wdata are ignored.
  - Write is captured at the clk edge where wr=1 and takes effect the following cycle.
- Phase accumulator:
  - If RUN=1: phase <= phase + FTW, modulo 2^16, wrap silent.
  - If RUN=0: phase holds.
  - FTW=0 with RUN=1 holds phase.
- Stage 1 (registered): p = phase + OFFSET mod 2^16; register p and WAVE.
- Stage 2 (registered into dout), computed from p:
  - sine: round(32767*sin(2*pi*p[15:8]/256)). Implemented with a 65-entry quarter-wave table (indices 0..64) plus mirror/negate symmetry; table entry 64 = 32767.
  - triangle: p<0x8000 -> 2p-32768; else 32767-2(p-32768).
  - sawtooth: p XOR 0x8000, as signed.
  - square: p[15]=0 -> +32767, else -32767.
- OEN and output:
  - OEN=0 -> dout=0.
  - OEN is pipelined alongside the data; out_valid = OEN delayed 2 cycles, so it rises/falls exactly 2 cycles after the CTRL write takes effect.
- Latency: phase -> dout = 2 cycles. Throughput: 1 sample/cycle.

Optional Feature:
Macro DDS_PHASE_OFFSET_EN.
- Defined: register 0x0010 OFFSET (16 bits) is writable and added to phase in stage 1.
- Undefined: writes to 0x0010 are ignored, OFFSET is constant 0, and no adder is synthesized.
- Latency is identical either way.

Decomposition:
- Package dds_pkg holds:
  - register address constants ADDR_OFFSET=0x0010, ADDR_FTW=0x0020, ADDR_CTRL=0x0030;
  - CTRL bit positions;
  - wave_e enum (SINE, TRI, SAW, SQR);
  - the quarter-wave sine table constant.
- One sub-module, dds_wave_gen, implements stage 2 (p, wave -> sample), purely combinational; the top holds the registers, accumulator and pipeline.

Test Plan:
- Reset: rst high 10 cycles, wr=0 -> dout=0 and out_valid=0 throughout; phase stays 0.
- Write CTRL=0x000F then FTW=0x0002 -> out_valid rises 2 cycles after the CTRL write takes effect; dout=+32767 (square, p<0x8000) until phase passes 0x8000, then -32767.
- CTRL=0x0003, FTW=0x0100 -> sine, period 256 cycles; dout sequence 0, 804, 1608, ...; 32767 at step 64; 0 at step 128; -32767 at step 192.
- CTRL=0x000B, FTW=0x1000 -> sawtooth -32768, -28672, -24576, ..., 28672, then wraps to -32768.
- Mid-run CTRL=0x0002 (RUN=0) -> dout freezes at its last value after 2 cycles, out_valid stays 1. Then CTRL=0x0001 (OEN=0) -> dout=0 and out_valid=0 two cycles later.
- Write to unmapped 0x0040 -> no change. Assert rst mid-waveform -> all registers and outputs 0 the next cycle. With DDS_PHASE_OFFSET_EN: OFFSET=0x4000 on sine at phase 0 -> dout=32767.
